renamed_regfile: RTL

- Parametrised architectural register file with a rename/busy table, for the Tomasulo core.
- Successor to the single-commit register block: configurable register count, data width and tag width.
- Adds NCOMMIT in-order commit ports, a uniform rename request/response handshake, and defined same-cycle priority rules.
- Sits between decode/dispatch (rename requests), the ROB (commit ports) and the branch predictor (flush).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_operand_read.sv | 40 ++++
 rtl/renamed_regfile.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the renamed register file
package regfile_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREG  = 32;
  localparam int DEF_TAG_W = 4;
  localparam int ZERO_REG  = 0;
  typedef logic [$clog2(DEF_NREG)-1:0] reg_idx_t;
  typedef logic [DEF_TAG_W-1:0] rob_tag_t;
  typedef struct packed {
    logic                busy;
    rob_tag_t            tag;
    logic [DEF_XLEN-1:0] data;
  } operand_t;
endpackage

// File: rtl/regfile_operand_read.sv
// regfile_operand_read: lookup of one source operand against the table entry and the commit bypass
module regfile_operand_read
  import regfile_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int NCOMMIT = 1,
  localparam int IW     = $clog2(NREG)
) (
  input  logic                     i_en,
  input  logic [IW-1:0]            i_idx,
  input  logic                     i_busy,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [XLEN-1:0]          i_val,
  input  logic [NCOMMIT-1:0]       i_cm_valid,
  input  logic [NCOMMIT*IW-1:0]    i_cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] i_cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  i_cm_value,
  output logic                     o_busy,
  output logic [TAG_W-1:0]         o_tag,
  output logic [XLEN-1:0]          o_data
);
  logic            w_hit;
  logic            w_zero;
  logic [XLEN-1:0] w_hit_val;
  always_comb begin
    w_hit     = 1'b0;
    w_hit_val = '0;
    for (int p = 0; p < NCOMMIT; p++)
      if (i_cm_valid[p] && i_cm_rd[p*IW +: IW] == i_idx && i_cm_tag[p*TAG_W +: TAG_W] == i_tag) begin
        w_hit     = 1'b1;
        w_hit_val = i_cm_value[p*XLEN +: XLEN];
      end
    w_zero = !i_en || int'(i_idx) == ZERO_REG;
    o_busy = !w_zero && i_busy && !w_hit;
    o_tag  = o_busy ? i_tag : '0;
    o_data = w_zero ? '0 : !i_busy ? i_val : w_hit ? w_hit_val : '0;
  end
endmodule

// File: rtl/renamed_regfile.sv
// renamed_regfile: register file with rename/busy table and NCOMMIT in-order commit ports
// REGFILE_DBG_EN adds a registered debug read port (dbg_addr/dbg_data/dbg_busy)
module renamed_regfile
  import regfile_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NREG    = DEF_NREG,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int NCOMMIT = 1,
  localparam int IW     = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     ren_valid,
  input  logic                     ren_src1_en,
  input  logic                     ren_src2_en,
  input  logic [IW-1:0]            ren_src1,
  input  logic [IW-1:0]            ren_src2,
  input  logic                     ren_rd_en,
  input  logic [IW-1:0]            ren_rd,
  input  logic [TAG_W-1:0]         ren_tag,
  output logic                     rsp_valid,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_op1_busy,
  output logic [TAG_W-1:0]         rsp_op1_tag,
  output logic [XLEN-1:0]          rsp_op1_data,
  output logic                     rsp_op2_busy,
  output logic [TAG_W-1:0]         rsp_op2_tag,
  output logic [XLEN-1:0]          rsp_op2_data,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*IW-1:0]    cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_value
`ifdef REGFILE_DBG_EN
  ,
  input  logic [IW-1:0]            dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic                     dbg_busy
`endif
);
  logic [XLEN-1:0]  r_val [NREG];
  logic [TAG_W-1:0] r_tag [NREG];
  logic [NREG-1:0]  r_busy;
  logic [XLEN-1:0]  w_val_n [NREG];
  logic [TAG_W-1:0] w_tag_n [NREG];
  logic [NREG-1:0]  w_busy_n;
  logic             w_acc;
  logic             w_b1, w_b2;
  logic [TAG_W-1:0] w_t1, w_t2;
  logic [XLEN-1:0]  w_d1, w_d2;
  assign w_acc = ren_valid && !flush;
  // commits first, then flush, then rename, so rename owns busy/tag on a collision
  always_comb begin
    w_val_n  = r_val;
    w_tag_n  = r_tag;
    w_busy_n = r_busy;
    for (int p = 0; p < NCOMMIT; p++)
      if (cm_valid[p] && int'(cm_rd[p*IW +: IW]) != ZERO_REG) begin
        w_val_n[cm_rd[p*IW +: IW]] = cm_value[p*XLEN +: XLEN];
        if (r_tag[cm_rd[p*IW +: IW]] == cm_tag[p*TAG_W +: TAG_W]) w_busy_n[cm_rd[p*IW +: IW]] = 1'b0;
      end
    if (flush) w_busy_n = '0;
    if (w_acc && ren_rd_en && int'(ren_rd) != ZERO_REG) begin
      w_busy_n[ren_rd] = 1'b1;
      w_tag_n[ren_rd]  = ren_tag;
    end
  end
  regfile_operand_read #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT)) u_op1 (
    .i_en(ren_src1_en), .i_idx(ren_src1), .i_busy(r_busy[ren_src1]), .i_tag(r_tag[ren_src1]),
    .i_val(r_val[ren_src1]), .i_cm_valid(cm_valid), .i_cm_rd(cm_rd), .i_cm_tag(cm_tag),
    .i_cm_value(cm_value), .o_busy(w_b1), .o_tag(w_t1), .o_data(w_d1)
  );
  regfile_operand_read #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT)) u_op2 (
    .i_en(ren_src2_en), .i_idx(ren_src2), .i_busy(r_busy[ren_src2]), .i_tag(r_tag[ren_src2]),
    .i_val(r_val[ren_src2]), .i_cm_valid(cm_valid), .i_cm_rd(cm_rd), .i_cm_tag(cm_tag),
    .i_cm_value(cm_value), .o_busy(w_b2), .o_tag(w_t2), .o_data(w_d2)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_val        <= '{default: '0};
      r_tag        <= '{default: '0};
      r_busy       <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_op1_busy <= 1'b0;
      rsp_op1_tag  <= '0;
      rsp_op1_data <= '0;
      rsp_op2_busy <= 1'b0;
      rsp_op2_tag  <= '0;
      rsp_op2_data <= '0;
    end else if (rdy) begin
      r_val        <= w_val_n;
      r_tag        <= w_tag_n;
      r_busy       <= w_busy_n;
      rsp_valid    <= w_acc;
      rsp_tag      <= ren_tag;
      rsp_op1_busy <= w_b1;
      rsp_op1_tag  <= w_t1;
      rsp_op1_data <= w_d1;
      rsp_op2_busy <= w_b2;
      rsp_op2_tag  <= w_t2;
      rsp_op2_data <= w_d2;
    end
`ifdef REGFILE_DBG_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      dbg_data <= '0;
      dbg_busy <= 1'b0;
    end else if (rdy) begin
      dbg_data <= w_val_n[dbg_addr];
      dbg_busy <= w_busy_n[dbg_addr];
    end
`endif
endmodule
